uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with a word queue in front of the frame FSM
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO; otherwise a single holding register.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_tick_1x,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_line,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   shreg;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   par_bit;

    logic                   q_empty;
    logic [DATA_BITS-1:0]   q_head;
    logic                   push;
    logic                   pop;
    logic                   stop_done;

    assign push      = tx_valid & tx_ready;
    assign stop_done = (state == ST_STOP) && (stop_cnt == 1'(STOP_BITS - 1));
    // The head word leaves the queue on the same tick its start bit goes out.
    assign pop       = baud_tick_1x && !q_empty && ((state == ST_IDLE) || stop_done);

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // Full blocks pushes even when a pop happens on the same edge.
    assign tx_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign q_empty  = (fifo_count == '0);
    assign q_head   = mem[rd_ptr];
`else
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_data  <= tx_data;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign tx_ready   = !hold_valid;
    assign q_empty    = !hold_valid;
    assign q_head     = hold_data;
    assign fifo_count = CW'(hold_valid);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (baud_tick_1x) begin
                if (stop_done)
                    tx_done <= 1'b1;
                if (pop) begin
                    shreg   <= q_head;
                    par_bit <= (PARITY == 2) ? ~^q_head : ^q_head;
                    tx_line <= 1'b0;
                    tx_busy <= 1'b1;
                    state   <= ST_START;
                end else begin
                    case (state)
                        ST_IDLE: ;
                        ST_START: begin
                            tx_line <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                        ST_DATA: begin
                            if (bit_cnt == 4'(DATA_BITS - 1)) begin
                                if (PARITY != 0) begin
                                    tx_line <= par_bit;
                                    state   <= ST_PARITY;
                                end else begin
                                    tx_line  <= 1'b1;
                                    stop_cnt <= 1'b0;
                                    state    <= ST_STOP;
                                end
                            end else begin
                                tx_line <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        ST_PARITY: begin
                            tx_line  <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (stop_done) begin
                                tx_busy <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg (default and 7O2 instances)
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick_1x;
    logic       valid_a, valid_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       ready_a, line_a, busy_a, done_a;
    logic       ready_b, line_b, busy_b, done_b;
    logic [2:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_cfg u_a (
        .clk(clk), .rst_n(rst_n), .baud_tick_1x(baud_tick_1x),
        .tx_valid(valid_a), .tx_data(data_a), .tx_ready(ready_a),
        .tx_line(line_a), .tx_busy(busy_a), .tx_done(done_a), .fifo_count(count_a)
    );

    uart_tx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .baud_tick_1x(baud_tick_1x),
        .tx_valid(valid_b), .tx_data(data_b), .tx_ready(ready_b),
        .tx_line(line_b), .tx_busy(busy_b), .tx_done(done_b), .fifo_count(count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        baud_tick_1x = 1'b1;
        @(posedge clk);
        #1;
        baud_tick_1x = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] d);
        valid_a = 1'b1;
        data_a  = d;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
    endtask

    // bits[n-1] is the first bit expected on the line; chained means the first tick also ends the previous frame.
    task automatic frame(input bit sel, input logic [15:0] bits, input int n, input bit chained, input string tag);
        for (int i = 0; i < n; i++) begin
            do_tick();
            check($sformatf("%s_line%0d", tag, i), sel ? line_b : line_a, bits[n-1-i]);
            check($sformatf("%s_done%0d", tag, i), sel ? done_b : done_a, (i == 0) && chained);
            check($sformatf("%s_busy%0d", tag, i), sel ? busy_b : busy_a, 1'b1);
            idle(1);
            check($sformatf("%s_hold%0d", tag, i), sel ? line_b : line_a, bits[n-1-i]);
        end
    endtask

    task automatic frame_end(input bit sel, input string tag);
        do_tick();
        check({tag, "_end_done"}, sel ? done_b : done_a, 1'b1);
        check({tag, "_end_busy"}, sel ? busy_b : busy_a, 1'b0);
        check({tag, "_end_line"}, sel ? line_b : line_a, 1'b1);
        idle(1);
        check({tag, "_end_pulse"}, sel ? done_b : done_a, 1'b0);
    endtask

`ifdef UART_TX_FIFO_EN
    logic [7:0] words [5] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'h55};
    logic [9:0] exp_f [4] = '{10'b0100000001, 10'b0000000011, 10'b0111111111, 10'b0001111001};
`endif

    initial begin
        rst_n        = 1'b0;
        baud_tick_1x = 1'b0;
        valid_a      = 1'b0;
        valid_b      = 1'b0;
        data_a       = '0;
        data_b       = '0;
        idle(2);
        check("rst_line", line_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_count", count_a, 3'd0);
        check("rst_line_b", line_b, 1'b1);
        valid_a = 1'b1;
        data_a  = 8'h0F;
        do_tick();
        valid_a = 1'b0;
        check("rst_ignore_count", count_a, 3'd0);
        check("rst_ignore_line", line_a, 1'b1);
        rst_n = 1'b1;
        idle(2);

        push_a(8'hA5);
        check("a5_count", count_a, 3'd1);
        idle(3);
        check("a5_wait_busy", busy_a, 1'b0);
        check("a5_wait_line", line_a, 1'b1);
        frame(1'b0, 16'b0101001011, 10, 1'b0, "a5");
        check("a5_count_after", count_a, 3'd0);
        frame_end(1'b0, "a5");

        valid_b = 1'b1;
        data_b  = 7'h03;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        frame(1'b1, 16'b01100000111, 11, 1'b0, "b03");
        frame_end(1'b1, "b03");

`ifdef UART_TX_FIFO_EN
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_a = words[i];
            @(posedge clk);
            #1;
            check($sformatf("fifo_ready%0d", i), ready_a, i < 3);
            check($sformatf("fifo_count%0d", i), count_a, (i < 4) ? i + 1 : 4);
        end
        valid_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            frame(1'b0, 16'(exp_f[k]), 10, k != 0, $sformatf("fifo%0d", k));
            check($sformatf("fifo_left%0d", k), count_a, 3 - k);
        end
        frame_end(1'b0, "fifo");
        check("fifo_empty", count_a, 3'd0);
`else
        push_a(8'h11);
        check("hold_ready1", ready_a, 1'b0);
        check("hold_count1", count_a, 3'd1);
        do_tick();
        check("hold_start", line_a, 1'b0);
        check("hold_ready_pop", ready_a, 1'b1);
        check("hold_count_pop", count_a, 3'd0);
        idle(1);
        push_a(8'h22);
        check("hold_ready2", ready_a, 1'b0);
        push_a(8'h77);
        check("hold_count2", count_a, 3'd1);
        frame(1'b0, 16'b100010001, 9, 1'b0, "h11");
        check("hold_ready_stop", ready_a, 1'b0);
        frame(1'b0, 16'b0010001001, 10, 1'b1, "h22");
        check("hold_ready_after", ready_a, 1'b1);
        check("hold_count_after", count_a, 3'd0);
        frame_end(1'b0, "h22");
`endif

        push_a(8'hA5);
        do_tick();
        push_a(8'h5A);
        repeat (4) do_tick();
        check("mid_line_bit3", line_a, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_line", line_a, 1'b1);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_count", count_a, 3'd0);
        check("mid_rst_ready", ready_a, 1'b1);
        check("mid_rst_done", done_a, 1'b0);
        valid_a = 1'b1;
        data_a  = 8'hFF;
        do_tick();
        valid_a = 1'b0;
        check("mid_rst_ignore", count_a, 3'd0);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check($sformatf("flush_line%0d", i), line_a, 1'b1);
            check($sformatf("flush_done%0d", i), done_a, 1'b0);
            check($sformatf("flush_busy%0d", i), busy_a, 1'b0);
        end
        push_a(8'h3C);
        frame(1'b0, 16'b0001111001, 10, 1'b0, "post");
        frame_end(1'b0, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
